// File: rtl/multdiv_ctrl.sv
// Iterative signed 32-bit multiply/divide sequencer: shift-add multiply and restoring
// divide over one shared add/subtract/shift datapath, fixed 33-cycle latency for both.
module multdiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy,
    output logic [1:0]       dbg_state_o
);
    localparam int W = WIDTH;
    localparam logic [W-1:0]   ONE     = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]   MIN_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [2*W-1:0] NEG_LIM = {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};
    localparam logic [5:0]     LAST    = 6'd31;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t       state_q;
    logic [5:0]   cnt_q;
    logic [W-1:0] hi_q;      // multiply accumulator / divide remainder
    logic [W-1:0] lo_q;      // multiplier / quotient
    logic [W-1:0] op_q;      // multiplicand magnitude / divisor magnitude
    logic         sign_a_q;
    logic         sign_b_q;
    logic         b_zero_q;

    logic         start;
    logic [W-1:0] a_mag, b_mag;
    logic [W:0]   mult_sum;
    logic [W-1:0] mult_hi_d, mult_lo_d;
    logic [W:0]   div_shift, div_trial;
    logic [W-1:0] div_hi_d, div_lo_d;
    logic [2*W-1:0] prod;
    logic         sign_neg, mneg, dneg;
    logic [W-1:0] mult_res_d, div_res_d;
    logic         mult_exc_d, div_exc_d;

    assign dbg_state_o = state_q;

    always_comb begin
        start = ((state_q == S_IDLE) || (state_q == S_DONE)) && (ctrl_MULT || ctrl_DIV);

        a_mag = data_operandA;
        if (data_operandA[W-1]) a_mag = ~data_operandA + ONE;
        b_mag = data_operandB;
        if (data_operandB[W-1]) b_mag = ~data_operandB + ONE;

        mult_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, op_q} : {(W+1){1'b0}});
        mult_hi_d = mult_sum[W:1];
        mult_lo_d = {mult_sum[0], lo_q[W-1:1]};

        // 0x80000000 magnitude is 2^31 unsigned, so the 33-bit trial never wraps
        div_shift = {hi_q, lo_q[W-1]};
        div_trial = div_shift - {1'b0, op_q};
        if (!div_trial[W]) begin
            div_hi_d = div_trial[W-1:0];
            div_lo_d = {lo_q[W-2:0], 1'b1};
        end else begin
            div_hi_d = div_shift[W-1:0];
            div_lo_d = {lo_q[W-2:0], 1'b0};
        end

        sign_neg   = sign_a_q ^ sign_b_q;
        prod       = {mult_hi_d, mult_lo_d};
        mneg       = sign_neg && (prod != '0);
        mult_res_d = mneg ? (~prod[W-1:0] + ONE) : prod[W-1:0];
        mult_exc_d = mneg ? (prod > NEG_LIM) : (prod[2*W-1:W-1] != '0);

        dneg      = sign_neg && (div_lo_d != '0);
        div_res_d = b_zero_q ? '0 : (dneg ? (~div_lo_d + ONE) : div_lo_d);
        div_exc_d = b_zero_q || (!sign_neg && (div_lo_d == MIN_NEG));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            hi_q           <= '0;
            lo_q           <= '0;
            op_q           <= '0;
            sign_a_q       <= 1'b0;
            sign_b_q       <= 1'b0;
            b_zero_q       <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        sign_a_q <= data_operandA[W-1];
                        sign_b_q <= data_operandB[W-1];
                        b_zero_q <= (data_operandB == '0);
                        hi_q     <= '0;
                        cnt_q    <= '0;
                        busy     <= 1'b1;
                        if (ctrl_MULT) begin
                            state_q <= S_MULT;
                            op_q    <= a_mag;
                            lo_q    <= b_mag;
                        end else begin
                            state_q <= S_DIV;
                            op_q    <= b_mag;
                            lo_q    <= a_mag;
                        end
                    end else begin
                        state_q <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                S_MULT: begin
                    hi_q  <= mult_hi_d;
                    lo_q  <= mult_lo_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == LAST) begin
                        state_q        <= S_DONE;
                        data_result    <= mult_res_d;
                        data_exception <= mult_exc_d;
                        data_resultRDY <= 1'b1;
                    end
                end
                S_DIV: begin
                    hi_q  <= div_hi_d;
                    lo_q  <= div_lo_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == LAST) begin
                        state_q        <= S_DONE;
                        data_result    <= div_res_d;
                        data_exception <= div_exc_d;
                        data_resultRDY <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multdiv_ctrl.sv
// Randomized and directed bench for multdiv_ctrl against a plain-arithmetic signed model.
module tb_multdiv_ctrl;
    logic        clock = 1'b0;
    logic        reset, ctrl_MULT, ctrl_DIV;
    logic [31:0] data_operandA, data_operandB, data_result;
    logic        data_exception, data_resultRDY, busy;
    logic [1:0]  dbg_state;

    int vectors = 0;
    int miscompares = 0;
    logic [32:0] exp_q[$];
    logic [32:0] last_exp = '0;

    multdiv_ctrl #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .data_result(data_result), .data_exception(data_exception),
        .data_resultRDY(data_resultRDY), .busy(busy), .dbg_state_o(dbg_state)
    );

    always #5 clock = ~clock;

    // Returns {exception, result} from signed 64-bit arithmetic.
    function automatic logic [32:0] model(input bit is_mult, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (is_mult) begin
            r = sa * sb;
            return {(r > 64'sd2147483647) || (r < -64'sd2147483648), r[31:0]};
        end
        if (b == 32'd0) return {1'b1, 32'd0};
        r = sa / sb;
        return {(r > 64'sd2147483647), r[31:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_result"}, 64'(data_result), 64'd0);
        check({tag, "_exc"}, 64'(data_exception), 64'd0);
        check({tag, "_rdy"}, 64'(data_resultRDY), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic drive_start(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
        ctrl_MULT = m;
        ctrl_DIV  = d;
        data_operandA = a;
        data_operandB = b;
        exp_q.push_back(model(m, a, b));
    endtask

    task automatic release_start();
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Called one cycle after the start edge; returns at the negedge inside the RDY cycle.
    task automatic wait_done(input string tag, input int inject_at);
        int lat;
        int busy_cnt;
        logic [32:0] e;
        lat = 1;
        busy_cnt = 0;
        while (!data_resultRDY && lat < 100) begin
            if (busy) busy_cnt++;
            ctrl_DIV = (lat == inject_at);
            @(negedge clock);
            lat++;
        end
        ctrl_DIV = 1'b0;
        if (busy) busy_cnt++;
        check({tag, "_latency"}, 64'(lat), 64'd33);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            last_exp = e;
            check({tag, "_result"}, 64'(data_result), 64'(e[31:0]));
            check({tag, "_exc"}, 64'(data_exception), 64'(e[32]));
        end
    endtask

    task automatic check_hold(input string tag);
        @(negedge clock);
        check({tag, "_hold_result"}, 64'(data_result), 64'(last_exp[31:0]));
        check({tag, "_hold_exc"}, 64'(data_exception), 64'(last_exp[32]));
        check({tag, "_hold_rdy"}, 64'(data_resultRDY), 64'd0);
        check({tag, "_hold_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic run_op(input string tag, input bit m, input bit d,
                          input logic [31:0] a, input logic [31:0] b, input int inject_at);
        @(negedge clock);
        drive_start(m, d, a, b);
        @(negedge clock);
        release_start();
        wait_done(tag, inject_at);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'(int'($urandom_range(0, 40)) - 20);
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'($urandom_range(0, 32'h0003_FFFF));
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] dir_a [6] = '{32'd7, 32'h0001_0000, 32'h8000_0000, 32'hFFFF_FF9C, 32'd5, 32'h8000_0000};
    logic [31:0] dir_b [6] = '{32'hFFFF_FFFD, 32'h0001_0000, 32'd1, 32'd7, 32'd0, 32'hFFFF_FFFF};
    bit          dir_m [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        int rdy_seen;
        bit m;
        reset = 1'b1;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(negedge clock);
        check_zero("por");
        check("por_state", 64'(dbg_state), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("dir%0d", i), dir_m[i], !dir_m[i], dir_a[i], dir_b[i], -1);
            check_hold($sformatf("dir%0d", i));
        end

        run_op("both_ctrl", 1'b1, 1'b1, 32'd1234, 32'hFFFF_FF00, -1);
        run_op("div_ignored", 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd6001, 10);
        check_hold("div_ignored");

        @(negedge clock);
        drive_start(1'b1, 1'b0, 32'd300, 32'd400);
        @(negedge clock);
        release_start();
        wait_done("b2b_first", -1);
        drive_start(1'b0, 1'b1, 32'hFFFF_0000, 32'd3);
        @(negedge clock);
        release_start();
        wait_done("b2b_second", -1);
        check_hold("b2b");

        @(negedge clock);
        drive_start(1'b0, 1'b1, 32'd1000, 32'd9);
        @(negedge clock);
        release_start();
        repeat (14) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        void'(exp_q.pop_back());
        check_zero("rst_mid");
        rdy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (data_resultRDY) rdy_seen++;
        end
        check("rst_no_rdy", 64'(rdy_seen), 64'd0);
        check_zero("rst_quiet");

        reset = 1'b1;
        ctrl_MULT = 1'b1;
        data_operandA = 32'd3;
        data_operandB = 32'd3;
        @(negedge clock);
        check("rst_prio_busy", 64'(busy), 64'd0);
        check("rst_prio_state", 64'(dbg_state), 64'd0);
        reset = 1'b0;
        drive_start(1'b1, 1'b0, 32'hFFFF_FFFE, 32'd50000);
        @(negedge clock);
        release_start();
        wait_done("after_rst", -1);

        for (int i = 0; i < 40; i++) begin
            m = 1'($urandom_range(0, 1));
            run_op($sformatf("rnd%0d", i), m, !m, rand_operand(), rand_operand(), -1);
        end
        check_hold("rnd_end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Multi-cycle sequencer for signed 32-bit multiply and divide, sitting beside the ALU in the execute stage. Accepts a one-cycle start command and iterates a shared add/subtract/shift datapath 32 times. Magnitudes and negations use the ALU's bitwise-NOT plus increment. Raises a one-cycle ready pulse with the result and an exception flag, letting the pipeline stall on `busy` instead of placing a 32×32 combinational array in the execute stage.

## Interface
- `WIDTH`, 32, operand/result width; only 32 is supported.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `ctrl_MULT` in 1: start multiply; sampled on the rising edge.
- `ctrl_DIV` in 1: start divide; sampled on the rising edge.
- `data_operandA` in 32: multiplicand/dividend, two's complement; captured only at start.
- `data_operandB` in 32: multiplier/divisor, two's complement; captured only at start.
- `data_result` out 32: product low word or quotient; held until the next start.
- `data_exception` out 1: overflow or divide-by-zero; valid with `data_resultRDY`, held with `data_result`.
- `data_resultRDY` out 1: one-cycle completion pulse.
- `busy` out 1: high from the cycle after start through the `data_resultRDY` cycle.

## Operation
- States: IDLE, MULT, DIV, DONE. Iteration counter is 6 bits, 0..31.
- **Start condition**
  - A start is accepted when the state is IDLE or DONE.
  - If both `ctrl_MULT` and `ctrl_DIV` are high, MULT wins.
- **On start**
  - Latch the sign bits and the magnitudes of A and B.
  - Magnitude is computed as NOT(x)+1 when x[31]=1.
  - Clear the accumulator/remainder and the counter.
  - Next state is MULT or DIV.
- **Start while busy:** `ctrl_*` pulses in MULT or DIV are ignored; the operation in progress continues unchanged.
- **MULT state (one iteration per cycle)**
  - Unsigned shift-add over the 64-bit {acc, multiplier} register.
  - If the multiplier LSB is 1, add the multiplicand magnitude to acc with a 33-bit sum, then shift right by 1.
  - When the counter reaches 31, go to DONE.
- **DIV state (one iteration per cycle)**
  - Restoring division on the {rem, quotient} register.
  - Shift left by 1, then compute trial = rem − |B| with a 33-bit result.
  - If trial ≥ 0: rem = trial and the quotient LSB = 1. Otherwise keep rem and the quotient LSB = 0.
  - When the counter reaches 31, go to DONE.
- **DONE (one cycle)**
  - `data_resultRDY`=1.
  - Next state is IDLE, unless a new start is sampled on this edge; that start is accepted.
- **Sign fix-up and exception (registered on the MULT/DIV→DONE edge)**
  - Mult: result = low 32 bits of the product, negated if signA≠signB. `data_exception`=1 if the signed 64-bit product lies outside [−2^31, 2^31−1].
  - A zero product is never flagged, and the result is not negated to −0.
  - Div: quotient truncates toward zero, sign = signA XOR signB. The remainder is discarded.
  - Div with B=0: result 0x00000000, `data_exception`=1. The full 32 iterations still run, so latency is uniform.
  - Div 0x80000000 / 0xFFFFFFFF: result 0x80000000, `data_exception`=1.
  - Magnitude of 0x80000000 is handled as 2^31 in the 33-bit datapath.
- **Reset**
  - Go to IDLE and clear the counter and all registers.
  - Outputs: `data_result`=0, `data_exception`=0, `data_resultRDY`=0, `busy`=0.
  - Reset mid-operation aborts it: no `data_resultRDY` pulse, and the outputs read 0.
  - Reset has priority over a simultaneous `ctrl_*`.

## Timing
- Start is sampled on edge E0.
- `busy` rises after E0.
- Iterations occur on edges E1..E32.
- The E32 edge enters DONE and registers the result and exception.
- `data_resultRDY` is high for exactly the cycle between E32 and E33.
- `busy` falls after E33, unless a back-to-back start was sampled on E33, in which case it stays high.
- Fixed latency: 33 cycles from the start edge to the RDY cycle, for both ops and all operand values.
- Back-to-back: the next start may be sampled on E33, giving a 33-cycle throughput.
- `data_result` and `data_exception` change only on a DONE-entry edge or on reset. They are stable between operations.
- All outputs are registered; there is no combinational input→output path.

## Test plan
- **Multiply 7 × −3:** `ctrl_MULT` pulse → RDY exactly 33 cycles later; result 0xFFFFFFEB, exception 0; `busy` high for 33 cycles.
- **Multiply overflow:** 0x00010000 × 0x00010000 → result 0x00000000, exception 1. Also 0x80000000 × 1 → 0x80000000, exception 0.
- **Divide −100 / 7:** → 0xFFFFFFF2 (−14), exception 0.
- **Divide 5 / 0:** → 0x00000000, exception 1, same latency.
- **Divide 0x80000000 / −1:** → 0x80000000, exception 1.
- **Start handling:**
  - Both `ctrl_*` high → multiply performed.
  - `ctrl_DIV` pulse at cycle 10 of a multiply → ignored; the multiply result is correct.
  - Start sampled on the RDY cycle → second RDY exactly 33 cycles later.
- **Reset mid-operation:** reset at cycle 15 of a divide → no RDY; all outputs 0.
- **Start after reset:** a new start on the next cycle completes normally.
